// File: rtl/ramb_asym_pkg.sv
// rtl/ramb_asym_pkg.sv - write-mode constants and geometry helpers for the asymmetric dual-port RAM
package ramb_asym_pkg;

  localparam int WM_WRITE_FIRST = 0;
  localparam int WM_READ_FIRST  = 1;
  localparam int WM_NO_CHANGE   = 2;

  // Smallest r with 2**r >= value; used for address and bit-index widths.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic logic is_pow2(input int value);
    return (value > 0) && ((value & (value - 1)) == 0);
  endfunction

  // Both widths and the array size must be powers of two, so the port ratio is one too.
  function automatic logic ratio_ok(input int total, input int wa, input int wb);
    return is_pow2(total) && is_pow2(wa) && is_pow2(wb) && (wa <= total) && (wb <= total);
  endfunction

endpackage

// File: rtl/ramb_asym_tdp_if.sv
// rtl/ramb_asym_tdp_if.sv - two-port access bundle (address, data, enables, outputs, collision flags)
interface ramb_asym_tdp_if #(
  parameter int TOTAL_BITS = 4096,
  parameter int WIDTH_A    = 1,
  parameter int WIDTH_B    = 8
);
  import ramb_asym_pkg::*;

  localparam int AW_A = clog2(TOTAL_BITS / WIDTH_A);
  localparam int AW_B = clog2(TOTAL_BITS / WIDTH_B);

  logic [AW_A-1:0]    ADDRA;
  logic [WIDTH_A-1:0] DIA;
  logic               ENA;
  logic               WEA;
  logic               RSTA;
  logic [WIDTH_A-1:0] DOA;

  logic [AW_B-1:0]    ADDRB;
  logic [WIDTH_B-1:0] DIB;
  logic               ENB;
  logic               WEB;
  logic               RSTB;
  logic [WIDTH_B-1:0] DOB;

  logic               COLL;
  logic [7:0]         COLL_CNT;

  modport master (
    output ADDRA, DIA, ENA, WEA, RSTA, ADDRB, DIB, ENB, WEB, RSTB,
    input  DOA, DOB, COLL, COLL_CNT
  );

  modport slave (
    input  ADDRA, DIA, ENA, WEA, RSTA, ADDRB, DIB, ENB, WEB, RSTB,
    output DOA, DOB, COLL, COLL_CNT
  );

endinterface

// File: rtl/ramb_asym_lane.sv
// rtl/ramb_asym_lane.sv - per-port bit base, bit mask and overlap against the other port
module ramb_asym_lane #(
  parameter int TOTAL_BITS = 4096,
  parameter int WIDTH      = 1,
  parameter int AW         = 12,
  parameter int BW         = 12
) (
  input  logic [AW-1:0]         addr,
  input  logic [TOTAL_BITS-1:0] other_mask,
  output logic [BW-1:0]         base,
  output logic [TOTAL_BITS-1:0] mask,
  output logic                  overlap
);
  import ramb_asym_pkg::*;

  localparam int SH = clog2(WIDTH);
  // Subtracting one from 1<<WIDTH also yields all ones when WIDTH equals TOTAL_BITS.
  localparam logic [TOTAL_BITS-1:0] WORD_ONES =
    (TOTAL_BITS'(1) << WIDTH) - TOTAL_BITS'(1);

  assign base    = BW'(addr) << SH;
  assign mask    = WORD_ONES << base;
  assign overlap = |(mask & other_mask);

endmodule

// File: rtl/ramb_asym_tdp.sv
// rtl/ramb_asym_tdp.sv - asymmetric true-dual-port RAM; RAMB_ASYM_TDP_DOREG_EN adds an output register stage
module ramb_asym_tdp #(
  parameter int                    TOTAL_BITS   = 4096,
  parameter int                    WIDTH_A      = 1,
  parameter int                    WIDTH_B      = 8,
  parameter int                    WRITE_MODE_A = 0,
  parameter int                    WRITE_MODE_B = 0,
  parameter logic [WIDTH_A-1:0]    SRVAL_A      = '0,
  parameter logic [WIDTH_B-1:0]    SRVAL_B      = '0,
  parameter logic [TOTAL_BITS-1:0] INIT         = '0
) (
  input logic            CLK,
  input logic            RST_N,
  ramb_asym_tdp_if.slave bus
);
  import ramb_asym_pkg::*;

  localparam int AW_A = clog2(TOTAL_BITS / WIDTH_A);
  localparam int AW_B = clog2(TOTAL_BITS / WIDTH_B);
  localparam int BW   = clog2(TOTAL_BITS);

  if (!ratio_ok(TOTAL_BITS, WIDTH_A, WIDTH_B)) begin : g_bad_geometry
    $error("ramb_asym_tdp: TOTAL_BITS, WIDTH_A and WIDTH_B must be powers of two with widths <= TOTAL_BITS");
  end

  // Array contents come up as INIT and are never touched by reset.
  logic [TOTAL_BITS-1:0] mem = INIT;
  logic [TOTAL_BITS-1:0] mem_next;
  logic [TOTAL_BITS-1:0] mask_a, mask_b, din_a, din_b;
  logic [BW-1:0]         base_a, base_b;
  logic                  ovl_a, ovl_b;
  logic                  wr_a, wr_b, coll_hit;
  logic [WIDTH_A-1:0]    rd_a, do_a;
  logic [WIDTH_B-1:0]    rd_b, do_b;
  logic                  coll_q;
  logic [7:0]            coll_cnt;

  ramb_asym_lane #(
    .TOTAL_BITS(TOTAL_BITS), .WIDTH(WIDTH_A), .AW(AW_A), .BW(BW)
  ) u_lane_a (
    .addr(bus.ADDRA), .other_mask(mask_b), .base(base_a), .mask(mask_a), .overlap(ovl_a)
  );

  ramb_asym_lane #(
    .TOTAL_BITS(TOTAL_BITS), .WIDTH(WIDTH_B), .AW(AW_B), .BW(BW)
  ) u_lane_b (
    .addr(bus.ADDRB), .other_mask(mask_a), .base(base_b), .mask(mask_b), .overlap(ovl_b)
  );

  assign wr_a     = bus.ENA & bus.WEA;
  assign wr_b     = bus.ENB & bus.WEB;
  assign din_a    = TOTAL_BITS'(bus.DIA) << base_a;
  assign din_b    = TOTAL_BITS'(bus.DIB) << base_b;
  // Reads always see pre-edge contents, so a reader in a collision gets old data.
  assign rd_a     = mem[base_a +: WIDTH_A];
  assign rd_b     = mem[base_b +: WIDTH_B];
  assign coll_hit = bus.ENA & bus.ENB & (bus.WEA | bus.WEB) & (ovl_a | ovl_b);

  // Merge both writes; port B is applied last so it owns any overlapping bits.
  always_comb begin
    mem_next = mem;
    if (wr_a) mem_next = (mem_next & ~mask_a) | (din_a & mask_a);
    if (wr_b) mem_next = (mem_next & ~mask_b) | (din_b & mask_b);
  end

  // Commit writes; block reset drops all port activity on that edge.
  always_ff @(posedge CLK) begin
    if (RST_N && (wr_a || wr_b)) mem <= mem_next;
  end

  // Port A output register: output reset, then read, then write-mode behaviour.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      do_a <= SRVAL_A;
    end else if (bus.ENA) begin
      if (bus.RSTA)                          do_a <= SRVAL_A;
      else if (!bus.WEA)                     do_a <= rd_a;
      else if (WRITE_MODE_A == WM_WRITE_FIRST) do_a <= bus.DIA;
      else if (WRITE_MODE_A == WM_READ_FIRST)  do_a <= rd_a;
    end
  end

  // Port B output register: same priority order as port A.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      do_b <= SRVAL_B;
    end else if (bus.ENB) begin
      if (bus.RSTB)                          do_b <= SRVAL_B;
      else if (!bus.WEB)                     do_b <= rd_b;
      else if (WRITE_MODE_B == WM_WRITE_FIRST) do_b <= bus.DIB;
      else if (WRITE_MODE_B == WM_READ_FIRST)  do_b <= rd_b;
    end
  end

  // Collision pulse and saturating collision counter.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      coll_q   <= 1'b0;
      coll_cnt <= 8'd0;
    end else begin
      coll_q <= coll_hit;
      if (coll_hit && (coll_cnt != 8'hFF)) coll_cnt <= coll_cnt + 8'd1;
    end
  end

`ifdef RAMB_ASYM_TDP_DOREG_EN
  logic [WIDTH_A-1:0] do_a_q;
  logic [WIDTH_B-1:0] do_b_q;
  logic               coll_q2;

  // Extra output stage, always loading; COLL rides along so it lines up with the data.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      do_a_q  <= SRVAL_A;
      do_b_q  <= SRVAL_B;
      coll_q2 <= 1'b0;
    end else begin
      do_a_q  <= bus.RSTA ? SRVAL_A : do_a;
      do_b_q  <= bus.RSTB ? SRVAL_B : do_b;
      coll_q2 <= coll_q;
    end
  end

  assign bus.DOA  = do_a_q;
  assign bus.DOB  = do_b_q;
  assign bus.COLL = coll_q2;
`else
  assign bus.DOA  = do_a;
  assign bus.DOB  = do_b;
  assign bus.COLL = coll_q;
`endif

  assign bus.COLL_CNT = coll_cnt;

endmodule

// File: tb/tb_ramb_asym_tdp.sv
// tb/tb_ramb_asym_tdp.sv - scoreboard bench over three write-mode variants of ramb_asym_tdp
module tb_ramb_asym_tdp;

`ifdef RAMB_ASYM_TDP_DOREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, ena, wea, rsta, dia, enb, web, rstb;
  logic [11:0] addra;
  logic [8:0]  addrb;
  logic [7:0]  dib;

  wire [2:0]      doa_w, coll_w;
  wire [2:0][7:0] dob_w, cnt_w;

  int errors = 0;
  int checks = 0;

  // Instance k: port B mode k; instance 2 has a READ_FIRST port A; instance 1 has nonzero SRVALs.
  for (genvar k = 0; k < 3; k++) begin : g_dut
    ramb_asym_tdp_if #(.TOTAL_BITS(4096), .WIDTH_A(1), .WIDTH_B(8)) bus ();
    assign bus.ADDRA = addra;
    assign bus.DIA   = dia;
    assign bus.ENA   = ena;
    assign bus.WEA   = wea;
    assign bus.RSTA  = rsta;
    assign bus.ADDRB = addrb;
    assign bus.DIB   = dib;
    assign bus.ENB   = enb;
    assign bus.WEB   = web;
    assign bus.RSTB  = rstb;
    assign doa_w[k]  = bus.DOA;
    assign dob_w[k]  = bus.DOB;
    assign coll_w[k] = bus.COLL;
    assign cnt_w[k]  = bus.COLL_CNT;
    ramb_asym_tdp #(
      .TOTAL_BITS(4096), .WIDTH_A(1), .WIDTH_B(8),
      .WRITE_MODE_A((k == 2) ? 1 : 0), .WRITE_MODE_B(k),
      .SRVAL_A((k == 1) ? 1'b1 : 1'b0), .SRVAL_B((k == 1) ? 8'h5A : 8'h00),
      .INIT((k == 0) ? 4096'hA5 : 4096'h0)
    ) u_dut (.CLK(clk), .RST_N(rst_n), .bus(bus));
  end

  function automatic int mode_a(int k);  return (k == 2) ? 1 : 0; endfunction
  function automatic int mode_b(int k);  return k; endfunction
  function automatic logic srv_a(int k);  return (k == 1) ? 1'b1 : 1'b0; endfunction
  function automatic logic [7:0] srv_b(int k); return (k == 1) ? 8'h5A : 8'h00; endfunction

  // Reference model state: array, first output stage, flags, and the optional second stage.
  logic [4095:0] mm [3];
  logic          m_a [3];
  logic [7:0]    m_b [3];
  logic          m_c [3];
  logic [7:0]    m_n [3];
  logic          s_a [3];
  logic [7:0]    s_b [3];
  logic          s_c [3];

  typedef struct {
    int         k;
    logic       doa;
    logic [7:0] dob;
    logic       coll;
    logic [7:0] cnt;
  } exp_t;
  exp_t sb [$];

  task automatic model_edge(input int k);
    logic       olda, hit;
    logic [7:0] oldb;
    olda = mm[k][int'(addra)];
    for (int i = 0; i < 8; i++) oldb[i] = mm[k][int'(addrb) * 8 + i];
    if (!rst_n) begin
      s_a[k] = srv_a(k); s_b[k] = srv_b(k); s_c[k] = 1'b0;
    end else begin
      s_a[k] = rsta ? srv_a(k) : m_a[k];
      s_b[k] = rstb ? srv_b(k) : m_b[k];
      s_c[k] = m_c[k];
    end
    if (!rst_n) begin
      m_a[k] = srv_a(k); m_b[k] = srv_b(k); m_c[k] = 1'b0; m_n[k] = 8'd0;
    end else begin
      if (ena) begin
        if (rsta)                m_a[k] = srv_a(k);
        else if (!wea)           m_a[k] = olda;
        else if (mode_a(k) == 0) m_a[k] = dia;
        else if (mode_a(k) == 1) m_a[k] = olda;
      end
      if (enb) begin
        if (rstb)                m_b[k] = srv_b(k);
        else if (!web)           m_b[k] = oldb;
        else if (mode_b(k) == 0) m_b[k] = dib;
        else if (mode_b(k) == 1) m_b[k] = oldb;
      end
      if (ena && wea) mm[k][int'(addra)] = dia;
      if (enb && web) for (int i = 0; i < 8; i++) mm[k][int'(addrb) * 8 + i] = dib[i];
      hit = ena && enb && (wea || web) && (addra[11:3] == addrb);
      m_c[k] = hit;
      if (hit && m_n[k] != 8'hFF) m_n[k] = m_n[k] + 8'd1;
    end
  endtask

  // Apply current stimulus for one edge, pushing the expected outputs for every instance.
  task automatic step();
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      model_edge(k);
      e.k = k;
`ifdef RAMB_ASYM_TDP_DOREG_EN
      e.doa = s_a[k]; e.dob = s_b[k]; e.coll = s_c[k];
`else
      e.doa = m_a[k]; e.dob = m_b[k]; e.coll = m_c[k];
`endif
      e.cnt = m_n[k];
      sb.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    rst_n = 1'b1; ena = 1'b0; wea = 1'b0; rsta = 1'b0; dia = 1'b0;
    enb = 1'b0; web = 1'b0; rstb = 1'b0; dib = 8'h00; addra = '0; addrb = '0;
  endtask

  task automatic out_wait();
    for (int i = 1; i < LAT; i++) begin
      idle();
      step();
    end
  endtask

  // Scoreboard: everything queued was driven before the preceding rising edge.
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (doa_w[e.k] !== e.doa) begin
        errors++; $display("FAIL sb_doa dut%0d t=%0t got %b exp %b", e.k, $time, doa_w[e.k], e.doa);
      end
      checks++;
      if (dob_w[e.k] !== e.dob) begin
        errors++; $display("FAIL sb_dob dut%0d t=%0t got %h exp %h", e.k, $time, dob_w[e.k], e.dob);
      end
      checks++;
      if (coll_w[e.k] !== e.coll) begin
        errors++; $display("FAIL sb_coll dut%0d t=%0t got %b exp %b", e.k, $time, coll_w[e.k], e.coll);
      end
      checks++;
      if (cnt_w[e.k] !== e.cnt) begin
        errors++; $display("FAIL sb_cnt dut%0d t=%0t got %0d exp %0d", e.k, $time, cnt_w[e.k], e.cnt);
      end
    end
  end

  task automatic test_reset();
    idle(); rst_n = 1'b0; step(); step();
    idle();
    checks++; if (doa_w[0] !== 1'b0)  begin errors++; $display("FAIL reset_doa got %b exp 0", doa_w[0]); end
    checks++; if (dob_w[0] !== 8'h00) begin errors++; $display("FAIL reset_dob got %h exp 00", dob_w[0]); end
    checks++; if (dob_w[1] !== 8'h5A) begin errors++; $display("FAIL reset_srval_b got %h exp 5a", dob_w[1]); end
    checks++; if (cnt_w[0] !== 8'd0)  begin errors++; $display("FAIL reset_cnt got %0d exp 0", cnt_w[0]); end
    checks++; if (coll_w[0] !== 1'b0) begin errors++; $display("FAIL reset_coll got %b exp 0", coll_w[0]); end
    enb = 1'b1; addrb = 9'd0; step(); idle(); out_wait();
    checks++; if (dob_w[0] !== 8'hA5) begin errors++; $display("FAIL init_read got %h exp a5", dob_w[0]); end
  endtask

  task automatic test_write_a();
    for (int i = 0; i < 8; i++) begin
      idle(); ena = 1'b1; wea = 1'b1; addra = 12'(i); dia = 1'b1; step();
    end
    idle(); enb = 1'b1; addrb = 9'd0; step(); idle(); out_wait();
    checks++; if (dob_w[0] !== 8'hFF) begin errors++; $display("FAIL narrow_to_wide got %h exp ff", dob_w[0]); end
    checks++; if (dob_w[2] !== 8'hFF) begin errors++; $display("FAIL narrow_to_wide_nc got %h exp ff", dob_w[2]); end
    for (int i = 0; i < 9; i++) begin
      idle(); ena = 1'b1; addra = 12'(i); step(); idle(); out_wait();
      checks++;
      if (doa_w[0] !== (i < 8)) begin
        errors++; $display("FAIL bit_read[%0d] got %b exp %b", i, doa_w[0], (i < 8));
      end
    end
  endtask

  task automatic test_write_modes();
    idle(); enb = 1'b1; web = 1'b1; addrb = 9'd5; dib = 8'h3C; step(); idle(); out_wait();
    checks++; if (dob_w[0] !== 8'h3C) begin errors++; $display("FAIL mode_wf got %h exp 3c", dob_w[0]); end
    checks++; if (dob_w[1] !== 8'h00) begin errors++; $display("FAIL mode_rf got %h exp 00", dob_w[1]); end
    checks++; if (dob_w[2] !== 8'hFF) begin errors++; $display("FAIL mode_nc got %h exp ff", dob_w[2]); end
    idle(); enb = 1'b1; addrb = 9'd5; step(); idle(); out_wait();
    checks++; if (dob_w[1] !== 8'h3C) begin errors++; $display("FAIL mode_rf_next got %h exp 3c", dob_w[1]); end
    checks++; if (dob_w[2] !== 8'h3C) begin errors++; $display("FAIL mode_nc_next got %h exp 3c", dob_w[2]); end
  endtask

  task automatic test_collision();
    idle(); ena = 1'b1; wea = 1'b1; addra = 12'd40; dia = 1'b0;
    enb = 1'b1; web = 1'b1; addrb = 9'd5; dib = 8'hFF; step();
    checks++; if (cnt_w[0] !== 8'd1) begin errors++; $display("FAIL coll_cnt got %0d exp 1", cnt_w[0]); end
    idle(); out_wait();
    checks++; if (coll_w[0] !== 1'b1) begin errors++; $display("FAIL coll_pulse got %b exp 1", coll_w[0]); end
    checks++; if (doa_w[0] !== 1'b0) begin errors++; $display("FAIL coll_wf_a got %b exp 0", doa_w[0]); end
    checks++; if (dob_w[0] !== 8'hFF) begin errors++; $display("FAIL coll_wf_b got %h exp ff", dob_w[0]); end
    checks++; if (dob_w[1] !== 8'h3C) begin errors++; $display("FAIL coll_rf_b got %h exp 3c", dob_w[1]); end
    idle(); step();
    checks++; if (coll_w[0] !== 1'b0) begin errors++; $display("FAIL coll_one_cycle got %b exp 0", coll_w[0]); end
    idle(); ena = 1'b1; addra = 12'd40; step(); idle(); out_wait();
    checks++; if (doa_w[0] !== 1'b1) begin errors++; $display("FAIL coll_b_wins got %b exp 1", doa_w[0]); end
  endtask

  task automatic test_boundary();
    idle(); ena = 1'b1; wea = 1'b1; addra = 12'd4095; dia = 1'b1; step();
    idle(); enb = 1'b1; addrb = 9'd511; step(); idle(); out_wait();
    checks++; if (dob_w[0] !== 8'h80) begin errors++; $display("FAIL top_word got %h exp 80", dob_w[0]); end
    idle(); ena = 1'b1; wea = 1'b1; addra = 12'd48; dia = 1'b1;
    enb = 1'b1; web = 1'b1; addrb = 9'd7; dib = 8'h00; step();
    checks++; if (cnt_w[0] !== 8'd1) begin errors++; $display("FAIL no_overlap_cnt got %0d exp 1", cnt_w[0]); end
    idle(); out_wait();
    checks++; if (coll_w[0] !== 1'b0) begin errors++; $display("FAIL no_overlap_coll got %b exp 0", coll_w[0]); end
  endtask

  task automatic test_output_reset();
    idle(); enb = 1'b1; rstb = 1'b1; web = 1'b1; addrb = 9'd7; dib = 8'h77; step(); idle(); out_wait();
    checks++; if (dob_w[1] !== 8'h5A) begin errors++; $display("FAIL rstb_srval got %h exp 5a", dob_w[1]); end
    checks++; if (dob_w[0] !== 8'h00) begin errors++; $display("FAIL rstb_zero got %h exp 00", dob_w[0]); end
    idle(); enb = 1'b1; addrb = 9'd7; step(); idle(); out_wait();
    checks++; if (dob_w[0] !== 8'h77) begin errors++; $display("FAIL rstb_write_kept got %h exp 77", dob_w[0]); end
  endtask

  task automatic test_reset_midop();
    idle(); rst_n = 1'b0; enb = 1'b1; web = 1'b1; addrb = 9'd6; dib = 8'h11; step();
    idle(); enb = 1'b1; addrb = 9'd6; step(); idle(); out_wait();
    checks++; if (dob_w[0] !== 8'h01) begin errors++; $display("FAIL reset_drops_write got %h exp 01", dob_w[0]); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 200; n++) begin
      rst_n = ($urandom_range(0, 15) != 0);
      ena = $urandom_range(0, 1); wea = $urandom_range(0, 1); rsta = ($urandom_range(0, 7) == 0);
      enb = $urandom_range(0, 1); web = $urandom_range(0, 1); rstb = ($urandom_range(0, 7) == 0);
      addra = 12'($urandom_range(0, 63)); addrb = 9'($urandom_range(0, 7));
      dia = $urandom_range(0, 1); dib = 8'($urandom_range(0, 255));
      step();
    end
  endtask

  task automatic test_saturation();
    for (int n = 0; n < 300; n++) begin
      idle(); ena = 1'b1; addra = 12'd0; enb = 1'b1; web = 1'b1; addrb = 9'd0; dib = 8'hFF; step();
    end
    checks++; if (cnt_w[0] !== 8'd255) begin errors++; $display("FAIL sat_cnt got %0d exp 255", cnt_w[0]); end
    checks++; if (cnt_w[1] !== 8'd255) begin errors++; $display("FAIL sat_cnt1 got %0d exp 255", cnt_w[1]); end
    idle(); rst_n = 1'b0; step();
    checks++; if (cnt_w[0] !== 8'd0) begin errors++; $display("FAIL sat_reset got %0d exp 0", cnt_w[0]); end
    idle(); enb = 1'b1; addrb = 9'd0; step(); idle(); out_wait();
    checks++; if (dob_w[0] !== 8'hFF) begin errors++; $display("FAIL retain_after_reset got %h exp ff", dob_w[0]); end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) mm[k] = (k == 0) ? 4096'hA5 : 4096'h0;
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    test_reset();
    test_write_a();
    test_write_modes();
    test_collision();
    test_boundary();
    test_output_reset();
    test_reset_midop();
    test_random();
    test_saturation();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL sb_drain got %0d entries exp 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ramb_asym_tdp.md
Name: ramb_asym_tdp

Overview:
- Parametrised successor to the fixed-geometry RAMB4 dual-port primitives: one block RAM with two independent read/write ports whose data widths are set by parameter, with a width-ratio power of two.
- Single-clock; adds selectable per-port write modes, deterministic collision resolution, and collision flag/counter outputs for formal and debug use.
- Sits in the unisim-style library beside the RAMB4_Sx_Sy cells as the generic building block for new asymmetric memories.

Parameters:
- TOTAL_BITS, 4096, array size in bits; power of two.
- WIDTH_A, 1, port A data width; power of two, ≤ TOTAL_BITS.
- WIDTH_B, 8, port B data width; power of two, ≤ TOTAL_BITS.
- WRITE_MODE_A, 0, port A mode: 0 WRITE_FIRST, 1 READ_FIRST, 2 NO_CHANGE.
- WRITE_MODE_B, 0, port B mode; same encoding as WRITE_MODE_A.
- SRVAL_A, 0, DOA value after reset; WIDTH_A bits.
- SRVAL_B, 0, DOB value after reset; WIDTH_B bits.
- INIT, 0, initial array contents; TOTAL_BITS bits, bit 0 = address 0 LSB.

Ports:
- CLK  in  1  single clock, rising edge.
- RST_N  in  1  synchronous active-low block reset.
- ADDRA  in  AW_A = clog2(TOTAL_BITS/WIDTH_A)  port A word address.
- DIA  in  WIDTH_A  port A write data.
- ENA  in  1  port A enable.
- WEA  in  1  port A write enable; qualified by ENA.
- RSTA  in  1  port A synchronous output set/reset, active-high; qualified by ENA.
- DOA  out  WIDTH_A  port A read data.
- ADDRB, DIB, ENB, WEB, RSTB, DOB  as port A, using WIDTH_B and AW_B.
- COLL  out  1  one-cycle pulse when a collision occurred on the previous edge.
- COLL_CNT  out  8  saturating collision count.

Behaviour:
- Reset: one clock and one reset only. Reset is synchronous and active-low (RST_N), sampled on the CLK rising edge.
  - When RST_N is low: DOA←SRVAL_A, DOB←SRVAL_B, COLL←0, COLL_CNT←0.
  - Array contents are not affected by reset. The array powers up to INIT.
  - Reset overrides all port activity on that edge; no writes occur.
- Bit mapping: a port-X word at address ADDRX occupies array bits [ADDRX*WIDTH_X +: WIDTH_X].
- Port access, each edge with ENX=1:
  - WEX=1: the addressed bits are written with DIX.
  - DOX update by mode:
    - WRITE_FIRST: DOX←DIX.
    - READ_FIRST: DOX←old contents.
    - NO_CHANGE: DOX holds.
  - WEX=0: DOX←addressed contents.
  - ENX=0: nothing is written and DOX holds.
- Output reset: RSTX=1 with ENX=1 forces DOX←SRVAL_X. It has priority over the read path. A write with WEX=1 still occurs.
- Latency: 1 CLK edge from address to DOX.
- Collision: ENA and ENB both high, the bit ranges of the two ports overlap, and at least one WE is high.
  - Write/write: overlapping bits take DIB (port B wins); non-overlapping bits are written normally. Each port's WRITE_FIRST output shows its own DI.
  - Write/read: the reading port's output shows old contents on overlapping bits, regardless of its mode.
  - Flags: COLL=1 on the following cycle. COLL_CNT increments and saturates at 255.
  - Non-overlapping addresses never collide.
- Wrap-around: addresses are full range by construction, so there is no out-of-range case.
- Reset mid-operation: any access on the reset edge is dropped. The port outputs SRVAL on the next cycle.

Optional Feature:
- Macro: RAMB_ASYM_TDP_DOREG_EN.
- Defined: one extra output register stage per port, giving read latency 2.
  - The stage is always enabled and loads SRVAL_X when RST_N=0 or RSTX=1.
  - COLL is delayed to align with the data it describes.
- Undefined: latency 1 as described above.

Decomposition:
- Package ramb_asym_pkg:
  - Write-mode constants WM_WRITE_FIRST, WM_READ_FIRST, WM_NO_CHANGE.
  - clog2 function.
  - Width-ratio checking function (elaboration error on a non-power-of-two ratio).
- One sub-module, ramb_asym_lane. It computes the bit base, bit mask and overlap of a port access, and is instantiated once per port plus the overlap compare. Storage and output registers stay in the top module.

Test Plan:
- Defaults; RST_N=0 for 2 cycles → DOA=0, DOB=0x00, COLL_CNT=0. Read ADDRB=0 with INIT=…A5 → DOB=0xA5 after 1 edge.
- WEA=1 writing DIA=1 to ADDRA=0..7 → read ADDRB=0 gives DOB=0xFF. A DOA read then shows each bit.
- WRITE_MODE_B=1: write DIB=0x3C to ADDRB=5 (old 0x00) → DOB=0x00. Next read → 0x3C. With mode 2, DOB holds its prior value.
- Simultaneous WEA (ADDRA=40, DIA=0) and WEB (ADDRB=5, DIB=0xFF) → bit 40 reads 1; COLL pulses one cycle; COLL_CNT=1.
- Collision forced 300 times → COLL_CNT=255, no wrap. RST_N=0 → COLL_CNT=0, contents retained.
- ENB=1, RSTB=1, WEB=1, DIB=0x77, SRVAL_B=0x5A → DOB=0x5A, and the array holds 0x77 on the next read. With RAMB_ASYM_TDP_DOREG_EN, all read checks shift by 1 cycle.
